// File: rtl/fpgalib_pkg.sv
// Shared display types: 5-bit hex code {dp, nibble} used by hexscan and hexdisp,
// plus the scan-slot state encoding.
package fpgalib_pkg;
  localparam int HEX_DP_BIT = 4;

  typedef logic [4:0] hexcode_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;
endpackage

// File: rtl/hexscan_scan_timer.sv
// Slot timer for hexscan: cycle counter within a slot, slot index and the
// blank/show phase, all held at slot 0 BLANK while disabled.
//   state    | meaning
//   ST_BLANK | guard interval at the start of a slot, all digits dark
//   ST_SHOW  | remainder of the slot, current digit lit
module scan_timer
  import fpgalib_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DWELL  = 50000,
  parameter int GUARD  = 500
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  output logic                      in_show_o,
  output logic [$clog2(DIGITS)-1:0] slot_o,
  output logic [$clog2(DIGITS)-1:0] slot_nxt_o,
  output logic                      wrap_o
);
  localparam int CW = $clog2(DWELL);
  localparam int SW = $clog2(DIGITS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  scan_state_e   state_q, state_d;
  logic          wrap;

  always_comb begin
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    state_d = state_q;
    wrap    = 1'b0;
    if (!enable_i) begin
      cnt_d   = '0;
      slot_d  = '0;
      state_d = ST_BLANK;
    end else if (cnt_q == CW'(DWELL - 1)) begin
      cnt_d   = '0;
      state_d = ST_BLANK;
      if (slot_q == SW'(DIGITS - 1)) begin
        slot_d = '0;
        wrap   = 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(GUARD - 1)) state_d = ST_SHOW;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      slot_q  <= '0;
      state_q <= ST_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      state_q <= state_d;
    end
  end

  assign in_show_o  = (state_q == ST_SHOW);
  assign slot_o     = slot_q;
  assign slot_nxt_o = slot_d;
  assign wrap_o     = wrap;
endmodule

// File: rtl/hexscan.sv
// Seven-segment scan controller: shadow/active code banks with frame-aligned
// commit, driving the current code and active-low digit enables.
module hexscan
  import fpgalib_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DWELL  = 50000,
  parameter int GUARD  = 500
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      load_i,
  input  logic [4*DIGITS-1:0]       value_i,
  input  logic [DIGITS-1:0]         dp_i,
  input  logic                      wr_i,
  input  logic [$clog2(DIGITS)-1:0] addr_i,
  input  logic [4:0]                data_i,
  output logic [4:0]                digit_o,
  output logic [DIGITS-1:0]         an_o,
  output logic                      frame_o,
  output logic                      pending_o
);
  localparam int SW = $clog2(DIGITS);

  hexcode_t shadow_q [DIGITS];
  hexcode_t shadow_d [DIGITS];
  hexcode_t active_q [DIGITS];
  hexcode_t active_d [DIGITS];
  hexcode_t digit_q, digit_d;
  logic     pending_q, pending_d;
  logic     frame_q;
  logic     in_show, wrap, commit, wrote;
  logic [SW-1:0] slot, slot_nxt;

  scan_timer #(
    .DIGITS (DIGITS),
    .DWELL  (DWELL),
    .GUARD  (GUARD)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (enable_i),
    .in_show_o  (in_show),
    .slot_o     (slot),
    .slot_nxt_o (slot_nxt),
    .wrap_o     (wrap)
  );

  // Commit reads the old shadow, so a write landing in the commit cycle waits a frame.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    wrote     = 1'b0;
    commit    = pending_q && (wrap || !enable_i);
    if (commit) active_d = shadow_q;
    if (load_i) begin
      for (int k = 0; k < DIGITS; k++) begin
        shadow_d[k][HEX_DP_BIT]  = dp_i[k];
        shadow_d[k][3:0]         = value_i[4*k +: 4];
      end
      wrote = 1'b1;
    end
    if (wr_i && (32'(addr_i) < DIGITS)) begin
      shadow_d[addr_i] = data_i;
      wrote            = 1'b1;
    end
    if (wrote)       pending_d = 1'b1;
    else if (commit) pending_d = 1'b0;
    digit_d = active_d[slot_nxt];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DIGITS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      digit_q   <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      digit_q   <= digit_d;
      pending_q <= pending_d;
      frame_q   <= wrap;
    end
  end

  assign digit_o   = digit_q;
  assign an_o      = in_show ? ~(DIGITS'(1) << slot) : '1;
  assign frame_o   = frame_q;
  assign pending_o = pending_q;
endmodule

// File: tb/tb_hexscan.sv
// Bench for hexscan: directed scenarios plus random traffic, checked every
// cycle against a frame-position reference model.
module tb_hexscan;
  localparam int D  = 4;
  localparam int DW = 10;
  localparam int G  = 2;
  localparam int FL = D * DW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable, load, wr;
  logic [15:0]  value;
  logic [3:0]   dp;
  logic [1:0]   addr;
  logic [4:0]   data;
  logic [4:0]   digit;
  logic [3:0]   an;
  logic         frame, pending;

  int checks = 0;
  int errors = 0;

  int         pos;
  logic       m_frame, m_pend;
  logic [4:0] m_sh [D];
  logic [4:0] m_ac [D];

  hexscan #(.DIGITS(D), .DWELL(DW), .GUARD(G)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .enable_i (enable),
    .load_i   (load),
    .value_i  (value),
    .dp_i     (dp),
    .wr_i     (wr),
    .addr_i   (addr),
    .data_i   (data),
    .digit_o  (digit),
    .an_o     (an),
    .frame_o  (frame),
    .pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0; m_frame = 1'b0; m_pend = 1'b0;
    for (int k = 0; k < D; k++) begin m_sh[k] = '0; m_ac[k] = '0; end
  endtask

  task automatic model_edge();
    logic commit, wrote;
    if (enable) begin
      m_frame = (pos == FL - 1);
      pos     = (pos + 1) % FL;
      commit  = m_pend && m_frame;
    end else begin
      pos = 0; m_frame = 1'b0;
      commit = m_pend;
    end
    if (commit) for (int k = 0; k < D; k++) m_ac[k] = m_sh[k];
    wrote = load | wr;
    if (load) for (int k = 0; k < D; k++) m_sh[k] = {dp[k], value[4*k +: 4]};
    if (wr) m_sh[addr] = data;
    if (wrote) m_pend = 1'b1;
    else if (commit) m_pend = 1'b0;
  endtask

  function automatic logic [3:0] exp_an();
    logic [3:0] e = 4'hF;
    if (pos % DW >= G) e[pos / DW] = 1'b0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("digit",   {27'd0, digit},   {27'd0, m_ac[pos / DW]});
    chk("an",      {28'd0, an},      {28'd0, exp_an()});
    chk("frame",   {31'd0, frame},   {31'd0, m_frame});
    chk("pending", {31'd0, pending}, {31'd0, m_pend});
  endtask

  task automatic adv_to_pos(input int p);
    for (int i = 0; i < 2 * FL && pos != p; i++) step();
    chk("adv_timeout", pos, p);
  endtask

  task automatic wait_frame();
    logic got = 1'b0;
    for (int i = 0; i < 2 * FL && !got; i++) begin
      step();
      got = frame;
    end
    chk("frame_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic walk_slots(input string tag, input logic [4:0] e0, e1, e2, e3);
    logic [4:0] ex [D];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    for (int s = 0; s < D; s++) begin
      chk(tag, {27'd0, digit}, {27'd0, ex[s]});
      repeat (DW) step();
    end
  endtask

  initial begin
    int last, cyc;
    rst_n = 1'b0; enable = 1'b1; load = 1'b0; wr = 1'b0;
    value = '0; dp = '0; addr = '0; data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an",      {28'd0, an},      32'hF);
    chk("rst_digit",   {27'd0, digit},   32'h0);
    chk("rst_frame",   {31'd0, frame},   32'h0);
    chk("rst_pending", {31'd0, pending}, 32'h0);
    rst_n = 1'b1;

    last = -1; cyc = 0;
    for (int i = 0; i < 130; i++) begin
      step(); cyc++;
      if (frame) begin
        if (last >= 0) chk("frame_period", cyc - last, FL);
        last = cyc;
      end
    end

    adv_to_pos(15);
    load = 1'b1; value = 16'h4321; dp = 4'b0100;
    step();
    load = 1'b0;
    chk("pend_after_load", {31'd0, pending}, 32'd1);
    wait_frame();
    walk_slots("load_slot", 5'h01, 5'h02, 5'h13, 5'h04);

    adv_to_pos(7);
    load = 1'b1; value = 16'hAAAA; dp = 4'b0000;
    wr = 1'b1; addr = 2'd2; data = 5'h0F;
    step();
    load = 1'b0; wr = 1'b0;
    wait_frame();
    walk_slots("overlay_slot", 5'h0A, 5'h0A, 5'h0F, 5'h0A);

    adv_to_pos(20);
    load = 1'b1; value = 16'h5555;
    step();
    load = 1'b0;
    adv_to_pos(FL - 1);
    wr = 1'b1; addr = 2'd1; data = 5'h17;
    step();
    wr = 1'b0;
    chk("commit_cycle_frame",   {31'd0, frame},   32'd1);
    chk("commit_cycle_pending", {31'd0, pending}, 32'd1);
    walk_slots("commit_old", 5'h05, 5'h05, 5'h05, 5'h05);
    chk("commit_next_frame", {31'd0, frame}, 32'd1);
    walk_slots("commit_new", 5'h05, 5'h17, 5'h05, 5'h05);

    wr = 1'b1; addr = 2'd0; data = 5'h19;
    step();
    wr = 1'b0;
    adv_to_pos(5);
    enable = 1'b0;
    step();
    chk("dis_an",      {28'd0, an},      32'hF);
    chk("dis_digit",   {27'd0, digit},   32'h19);
    chk("dis_pending", {31'd0, pending}, 32'd0);
    repeat (4) step();
    enable = 1'b1;
    step();
    chk("reen_blank", {28'd0, an}, 32'hF);
    step();
    chk("reen_show0", {28'd0, an}, 32'hE);

    adv_to_pos(DW + 5);
    rst_n = 1'b0;
    #2;
    chk("async_an",    {28'd0, an},      32'hF);
    chk("async_digit", {27'd0, digit},   32'h0);
    chk("async_pend",  {31'd0, pending}, 32'h0);
    #1;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 900; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      load   = ($urandom_range(0, 11) == 0);
      wr     = ($urandom_range(0, 3) == 0);
      addr   = 2'($urandom_range(0, 3));
      data   = 5'($urandom);
      value  = 16'($urandom);
      dp     = 4'($urandom);
      step();
    end
    enable = 1'b1; load = 1'b0; wr = 1'b0;
    repeat (2 * FL) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
